// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with one-cycle read return
//
// Arbitrates the core LSU (port 0) and the DMA/debug master (port 1) onto a
// single word memory port with one-cycle registered read latency.
//
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : round-robin arbitration between the two ports
//   undefined : fixed priority, port 0 wins simultaneous requests
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_req, mN_we              access request and write select (N = 0, 1)
//   mN_addr, mN_wdata          byte address and write data
//   mN_gnt                     request accepted this cycle (combinational)
//   mN_rvalid, mN_rdata        one-cycle read data return, rdata 0 when idle
//   mem_wr_en, mem_addr        memory port controls, 0 when nothing granted
//   mem_data_wr, mem_data_rd   memory write data / registered read data
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_wr,
  input  logic [DATA_WIDTH-1:0] mem_data_rd
);

  // Priority pointer: the port that wins when both request. Always 0 in the
  // fixed-priority build, so the arbitration logic is shared by both builds.
  logic ptr;
  logic pend_valid;
  logic pend_port;

  // Grants are combinational so an accepted access reaches the memory in the
  // same cycle; reset gates them off while rst_n is low.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        m0_gnt = ~ptr;
        m1_gnt = ptr;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_data_wr = '0;
    if (m0_gnt) begin
      mem_wr_en   = m0_we;
      mem_addr    = m0_addr;
      mem_data_wr = m0_wdata;
    end else if (m1_gnt) begin
      mem_wr_en   = m1_we;
      mem_addr    = m1_addr;
      mem_data_wr = m1_wdata;
    end
  end

  // A granted read is remembered for one cycle so the memory's registered
  // read data can be steered back to the requester that issued it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
      ptr        <= 1'b0;
    end else begin
      pend_valid <= (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
      pend_port  <= m1_gnt;
`ifdef DMEM_ARB_RR_EN
      // Hand priority to the port that was not just served.
      if (m0_gnt || m1_gnt) begin
        ptr <= m0_gnt;
      end
`else
      ptr <= 1'b0;
`endif
    end
  end

  assign m0_rvalid = pend_valid && !pend_port;
  assign m1_rvalid = pend_valid && pend_port;
  assign m0_rdata  = m0_rvalid ? mem_data_rd : '0;
  assign m1_rdata  = m1_rvalid ? mem_data_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_data_wr;
  logic [31:0] mem_data_rd = '0;
  logic [31:0] mem [0:1023];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Word memory with one-cycle registered read latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[11:2]] <= mem_data_wr;
    mem_data_rd <= mem[mem_addr[11:2]];
  end

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd)
  );

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hFFFF_FFFF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    #1;
    total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); else pass_cnt++;
    total_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); else pass_cnt++;
    total_cnt++; if ({m0_rdata, m1_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h want 0", {m0_rdata, m1_rdata}); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr, mem_data_wr} !== 65'h0) $display("FAIL reset_mem: got %h want 0", {mem_wr_en, mem_addr, mem_data_wr}); else pass_cnt++;
    @(negedge clk);
    // Release and request in the same cycle: grant must be immediate.
    rst_n = 1'b1;
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h0;
    #1;
    total_cnt++; if (m0_gnt !== 1'b1) $display("FAIL first_gnt: got %b want 1", m0_gnt); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    #1;
    total_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL first_rvalid: got %b want 1", m0_rvalid); else pass_cnt++;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (m0_gnt !== 1'b1) $display("FAIL sr_wr_gnt: got %b want 1", m0_gnt); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr, mem_data_wr} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) $display("FAIL sr_wr_mem: got %h want %h", {mem_wr_en, mem_addr, mem_data_wr}, {1'b1, 32'h100, 32'hDEAD_BEEF}); else pass_cnt++;
    @(negedge clk);
    m0_we = 1'b0; m0_wdata = '0;
    #1;
    total_cnt++; if (m0_gnt !== 1'b1) $display("FAIL sr_rd_gnt: got %b want 1", m0_gnt); else pass_cnt++;
    total_cnt++; if (mem_wr_en !== 1'b0) $display("FAIL sr_rd_wren: got %b want 0", mem_wr_en); else pass_cnt++;
    total_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL sr_wr_no_rvalid: got %b want 0", m0_rvalid); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    #1;
    total_cnt++; if (m0_rvalid !== 1'b1) $display("FAIL sr_rvalid: got %b want 1", m0_rvalid); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL sr_rdata: got %h want deadbeef", m0_rdata); else pass_cnt++;
    total_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL sr_m1_rvalid: got %b want 0", m1_rvalid); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr} !== 33'h0) $display("FAIL sr_mem_idle: got %h want 0", {mem_wr_en, mem_addr}); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (m0_rvalid !== 1'b0) $display("FAIL sr_rvalid_pulse: got %b want 0", m0_rvalid); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h0) $display("FAIL sr_rdata_zero: got %h want 0", m0_rdata); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    #1;
    total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL b2b_wr_gnt: got %b want 01", {m0_gnt, m1_gnt}); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr, mem_data_wr} !== {1'b1, 32'h20, 32'h1234_5678}) $display("FAIL b2b_wr_mem: got %h want %h", {mem_wr_en, mem_addr, mem_data_wr}, {1'b1, 32'h20, 32'h1234_5678}); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h20;
    #1;
    total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL b2b_rd_gnt: got %b want 10", {m0_gnt, m1_gnt}); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr} !== {1'b0, 32'h20}) $display("FAIL b2b_rd_mem: got %h want %h", {mem_wr_en, mem_addr}, {1'b0, 32'h20}); else pass_cnt++;
    total_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL b2b_wr_no_rvalid: got %b want 0", m1_rvalid); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
    #1;
    total_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b10) $display("FAIL b2b_rvalid: got %b want 10", {m0_rvalid, m1_rvalid}); else pass_cnt++;
    total_cnt++; if (m0_rdata !== 32'h1234_5678) $display("FAIL b2b_rdata: got %h want 12345678", m0_rdata); else pass_cnt++;
  endtask

`ifdef DMEM_ARB_RR_EN
  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b01;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h20;
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 4) begin
        total_cnt++; if ({m0_gnt, m1_gnt} !== exp_gnt[i]) $display("FAIL rr_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, exp_gnt[i]); else pass_cnt++;
      end
      if (i > 0) begin
        total_cnt++; if ({m0_rvalid, m1_rvalid} !== exp_gnt[i-1]) $display("FAIL rr_rvalid[%0d]: got %b want %b", i, {m0_rvalid, m1_rvalid}, exp_gnt[i-1]); else pass_cnt++;
        if (exp_gnt[i-1] == 2'b10) begin
          total_cnt++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL rr_m0_rdata[%0d]: got %h want deadbeef", i, m0_rdata); else pass_cnt++;
        end else begin
          total_cnt++; if (m1_rdata !== 32'h1234_5678) $display("FAIL rr_m1_rdata[%0d]: got %h want 12345678", i, m1_rdata); else pass_cnt++;
        end
      end
    end
  endtask
`else
  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) begin
        m0_req = 1'b1; m0_addr = 32'h100;
        m1_req = 1'b1; m1_addr = 32'h20;
      end else if (i == 3) begin
        m0_req = 1'b0; m0_addr = '0;
      end else begin
        idle_inputs();
      end
      #1;
      if (i < 3) begin
        total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL fp_gnt[%0d]: got %b want 10", i, {m0_gnt, m1_gnt}); else pass_cnt++;
      end else if (i == 3) begin
        total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL fp_m1_gnt: got %b want 01", {m0_gnt, m1_gnt}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h20) $display("FAIL fp_m1_addr: got %h want 20", mem_addr); else pass_cnt++;
      end
      if (i >= 1 && i <= 3) begin
        total_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b10) $display("FAIL fp_rvalid[%0d]: got %b want 10", i, {m0_rvalid, m1_rvalid}); else pass_cnt++;
        total_cnt++; if (m0_rdata !== 32'hDEAD_BEEF) $display("FAIL fp_m0_rdata[%0d]: got %h want deadbeef", i, m0_rdata); else pass_cnt++;
      end
      if (i == 4) begin
        total_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b01) $display("FAIL fp_m1_rvalid: got %b want 01", {m0_rvalid, m1_rvalid}); else pass_cnt++;
        total_cnt++; if (m1_rdata !== 32'h1234_5678) $display("FAIL fp_m1_rdata: got %h want 12345678", m1_rdata); else pass_cnt++;
      end
    end
  endtask
`endif

  task automatic test_reset_mid_read();
    // An m0 grant first, so a round-robin pointer would sit at port 1.
    @(negedge clk);
    idle_inputs();
    m0_req = 1'b1; m0_addr = 32'h100;
    @(negedge clk);
    idle_inputs();
    m1_req = 1'b1; m1_addr = 32'h20;
    #1;
    total_cnt++; if (m1_gnt !== 1'b1) $display("FAIL rmr_gnt: got %b want 1", m1_gnt); else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0) $display("FAIL rmr_ctl_zero: got %b want 0000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); else pass_cnt++;
    total_cnt++; if ({mem_wr_en, mem_addr, mem_data_wr, m0_rdata, m1_rdata} !== 129'h0) $display("FAIL rmr_data_zero: got %h want 0", {mem_wr_en, mem_addr, mem_data_wr, m0_rdata, m1_rdata}); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({m1_rvalid, m1_rdata} !== 33'h0) $display("FAIL rmr_rvalid_in_reset: got %h want 0", {m1_rvalid, m1_rdata}); else pass_cnt++;
    rst_n = 1'b1;
    idle_inputs();
    #1;
    total_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL rmr_rvalid_release: got %b want 0", m1_rvalid); else pass_cnt++;
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h100;
    m1_req = 1'b1; m1_addr = 32'h20;
    #1;
    total_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL rmr_rvalid_late: got %b want 0", m1_rvalid); else pass_cnt++;
    total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rmr_ptr: got %b want 10", {m0_gnt, m1_gnt}); else pass_cnt++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      total_cnt++; if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL idle_gnt[%0d]: got %b want 00", i, {m0_gnt, m1_gnt}); else pass_cnt++;
      total_cnt++; if ({mem_wr_en, mem_addr} !== 33'h0) $display("FAIL idle_mem[%0d]: got %h want 0", i, {mem_wr_en, mem_addr}); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL idle_rvalid[%0d]: got %b want 00", i, {m0_rvalid, m1_rvalid}); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
`ifdef DMEM_ARB_RR_EN
    test_round_robin();
`else
    test_fixed_priority();
`endif
    test_reset_mid_read();
    test_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
